// File: rtl/i2c_bus_bridge.sv
// Bridges I2C slave byte strobes to 32-bit word cycles on the register bus:
// write-combining for partial writes, read prefetch so the slave always sees valid data.
module i2c_bus_bridge #(
  parameter int ADDR_W    = 8,
  parameter int FLUSH_TMO = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AS,
  input  logic              WR,
  input  logic              RD,
  input  logic [7:0]        I2CDI,
  output logic [7:0]        I2CDO,
  output logic              BREQ,
  output logic              BWE,
  output logic [ADDR_W-3:0] BADDR,
  output logic [31:0]       BDATO,
  output logic [3:0]        BBE,
  input  logic [31:0]       BDATI,
  input  logic              BACK,
  output logic              ERR,
  input  logic              ERRCLR
);

  localparam int TMO_W = $clog2(FLUSH_TMO) + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(FLUSH_TMO - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WCYC = 2'd1,
    RCYC = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [31:0]        rbuf_q, rbuf_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        wbuf_q, wbuf_d;
  logic [3:0]         wbe_q, wbe_d;
  logic [ADDR_W-3:0]  waddr_q, waddr_d;
  logic               wpend_q, wpend_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               stale_q, stale_d;
  logic               err_q, err_d;
  logic               breq_q, breq_d;
  logic               bwe_q, bwe_d;
  logic [ADDR_W-3:0]  baddr_q, baddr_d;
  logic [31:0]        bdato_q, bdato_d;
  logic [3:0]         bbe_q, bbe_d;
  logic [7:0]         i2cdo_q, i2cdo_d;

  logic               strobe_s;
  logic               stale_evt_s;
  logic               err_evt_s;
  logic [1:0]         lane_s;
  logic [ADDR_W-1:0]  ptr_inc_s;

  // State register with synchronous reset; reset also abandons any bus cycle in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rbuf_q   <= 32'h0000_0000;
      rvalid_q <= 1'b0;
      wbuf_q   <= 32'h0000_0000;
      wbe_q    <= 4'b0000;
      waddr_q  <= '0;
      wpend_q  <= 1'b0;
      tmo_q    <= '0;
      stale_q  <= 1'b0;
      err_q    <= 1'b0;
      breq_q   <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      bdato_q  <= 32'h0000_0000;
      bbe_q    <= 4'b0000;
      i2cdo_q  <= 8'hFF;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rbuf_q   <= rbuf_d;
      rvalid_q <= rvalid_d;
      wbuf_q   <= wbuf_d;
      wbe_q    <= wbe_d;
      waddr_q  <= waddr_d;
      wpend_q  <= wpend_d;
      tmo_q    <= tmo_d;
      stale_q  <= stale_d;
      err_q    <= err_d;
      breq_q   <= breq_d;
      bwe_q    <= bwe_d;
      baddr_q  <= baddr_d;
      bdato_q  <= bdato_d;
      bbe_q    <= bbe_d;
      i2cdo_q  <= i2cdo_d;
    end
  end

  // Strobe handling, flush timer, error flag and bus FSM next-state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rbuf_d      = rbuf_q;
    rvalid_d    = rvalid_q;
    wbuf_d      = wbuf_q;
    wbe_d       = wbe_q;
    waddr_d     = waddr_q;
    wpend_d     = wpend_q;
    tmo_d       = tmo_q;
    stale_d     = stale_q;
    err_d       = err_q;
    breq_d      = breq_q;
    bwe_d       = bwe_q;
    baddr_d     = baddr_q;
    bdato_d     = bdato_q;
    bbe_d       = bbe_q;
    strobe_s    = AS | WR | RD;
    ptr_inc_s   = ptr_q + PTR_ONE;
    lane_s      = ptr_q[1:0];
    stale_evt_s = 1'b0;
    err_evt_s   = 1'b0;

    // The slave never issues two strobes at once; AS takes precedence if it did
    if (AS) begin
      ptr_d       = ADDR_W'(I2CDI);
      rvalid_d    = 1'b0;
      wpend_d     = wpend_q | (wbe_q != 4'b0000);
      stale_evt_s = 1'b1;
    end else if (WR) begin
      stale_evt_s = 1'b1;
      if (wpend_q) begin
        err_evt_s = 1'b1;
      end else begin
        wbuf_d[{lane_s, 3'b000} +: 8] = I2CDI;
        wbe_d[lane_s] = 1'b1;
        waddr_d       = ptr_q[ADDR_W-1:2];
        ptr_d         = ptr_inc_s;
        rvalid_d      = 1'b0;
        wpend_d       = (lane_s == 2'd3);
      end
    end else if (RD) begin
      err_evt_s = ~rvalid_q;
      ptr_d     = ptr_inc_s;
      if (ptr_inc_s[1:0] == 2'b00) begin
        rvalid_d    = 1'b0;
        stale_evt_s = 1'b1;
      end else begin
        rvalid_d = rvalid_q;
      end
    end else begin
      stale_evt_s = 1'b0;
    end

    if ((wbe_q == 4'b0000) || (WR && !wpend_q)) begin
      tmo_d = '0;
    end else if (wpend_q) begin
      tmo_d = tmo_q;
    end else if (tmo_q == TMO_LAST) begin
      wpend_d = 1'b1;
      tmo_d   = tmo_q;
    end else begin
      tmo_d = tmo_q + TMO_ONE;
    end

    if (err_evt_s) begin
      err_d = 1'b1;
    end else if (ERRCLR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    // Launching a write empties the buffer this edge, overriding any strobe update above
    case (state_q)
      IDLE: begin
        if (wpend_q) begin
          state_d = WCYC;
          breq_d  = 1'b1;
          bwe_d   = 1'b1;
          baddr_d = waddr_q;
          bdato_d = wbuf_q;
          bbe_d   = wbe_q;
          wbe_d   = 4'b0000;
          wpend_d = 1'b0;
          tmo_d   = '0;
        end else if (!rvalid_q && (wbe_q == 4'b0000) && !strobe_s) begin
          state_d = RCYC;
          breq_d  = 1'b1;
          bwe_d   = 1'b0;
          bbe_d   = 4'b0000;
          baddr_d = ptr_q[ADDR_W-1:2];
          stale_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WCYC: begin
        if (BACK) begin
          state_d = IDLE;
          breq_d  = 1'b0;
        end else begin
          state_d = WCYC;
        end
      end
      RCYC: begin
        stale_d = stale_q | stale_evt_s;
        if (BACK) begin
          state_d  = IDLE;
          breq_d   = 1'b0;
          rbuf_d   = BDATI;
          rvalid_d = ~(stale_q | stale_evt_s);
        end else begin
          state_d = RCYC;
        end
      end
      default: begin
        state_d = IDLE;
        breq_d  = 1'b0;
      end
    endcase

    if (rvalid_d) begin
      i2cdo_d = rbuf_d[{ptr_d[1:0], 3'b000} +: 8];
    end else begin
      i2cdo_d = 8'hFF;
    end
  end

  assign I2CDO = i2cdo_q;
  assign BREQ  = breq_q;
  assign BWE   = bwe_q;
  assign BADDR = baddr_q;
  assign BDATO = bdato_q;
  assign BBE   = bbe_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_i2c_bus_bridge.sv
// Directed bench for i2c_bus_bridge: bus cycles are served by hand and every
// expected value is a hand-computed constant.
module tb_i2c_bus_bridge;

  localparam int ADDR_W    = 8;
  localparam int FLUSH_TMO = 32;

  logic              CLK = 1'b0;
  logic              RST, AS, WR, RD, BACK, ERRCLR;
  logic [7:0]        I2CDI;
  logic [7:0]        I2CDO;
  logic              BREQ, BWE, ERR;
  logic [ADDR_W-3:0] BADDR;
  logic [31:0]       BDATO, BDATI;
  logic [3:0]        BBE;

  int n_checks = 0;
  int n_errors = 0;

  i2c_bus_bridge #(.ADDR_W(ADDR_W), .FLUSH_TMO(FLUSH_TMO)) dut (
    .CLK(CLK), .RST(RST), .AS(AS), .WR(WR), .RD(RD), .I2CDI(I2CDI), .I2CDO(I2CDO),
    .BREQ(BREQ), .BWE(BWE), .BADDR(BADDR), .BDATO(BDATO), .BBE(BBE),
    .BDATI(BDATI), .BACK(BACK), .ERR(ERR), .ERRCLR(ERRCLR)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_as(input logic [7:0] b);
    AS = 1'b1; I2CDI = b; step(); AS = 1'b0;
  endtask

  task automatic do_wr(input logic [7:0] b);
    WR = 1'b1; I2CDI = b; step(); WR = 1'b0;
  endtask

  task automatic do_rd();
    RD = 1'b1; step(); RD = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget, output int waited);
    waited = 0;
    while ((BREQ !== 1'b1) && (waited < budget)) begin
      step();
      waited++;
    end
    check_val({tag, "_breq"}, 32'(BREQ), 32'd1);
  endtask

  task automatic expect_req(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] mask,
                            input logic [3:0] be);
    check_val({tag, "_bwe"}, 32'(BWE), 32'(we));
    check_val({tag, "_baddr"}, 32'(BADDR), addr);
    check_val({tag, "_bbe"}, 32'(BBE), 32'(be));
    if (we) check_val({tag, "_bdato"}, BDATO & mask, data);
  endtask

  task automatic ack(input string tag, input logic [31:0] data);
    BACK = 1'b1; BDATI = data; step(); BACK = 1'b0; BDATI = 32'h0;
    check_val({tag, "_breq_drop"}, 32'(BREQ), 32'd0);
  endtask

  initial begin
    int w;
    int early;
    RST = 1'b1; AS = 1'b0; WR = 1'b0; RD = 1'b0; BACK = 1'b0; ERRCLR = 1'b0;
    I2CDI = 8'h00; BDATI = 32'h0;
    step(); step();
    check_val("rst_breq", 32'(BREQ), 32'd0);
    check_val("rst_bwe", 32'(BWE), 32'd0);
    check_val("rst_baddr", 32'(BADDR), 32'd0);
    check_val("rst_bdato", BDATO, 32'd0);
    check_val("rst_bbe", 32'(BBE), 32'd0);
    check_val("rst_err", 32'(ERR), 32'd0);
    check_val("rst_i2cdo", 32'(I2CDO), 32'h0000_00FF);

    // First fetch one cycle after reset release
    RST = 1'b0; step();
    check_val("ff_breq", 32'(BREQ), 32'd1);
    expect_req("ff", 1'b0, 32'd0, 32'd0, 32'd0, 4'b0000);
    ack("ff", 32'h0302_0100);
    check_val("ff_i2cdo", 32'(I2CDO), 32'h00);

    // Full-word write
    do_as(8'h10); do_wr(8'h11); do_wr(8'h22); do_wr(8'h33); do_wr(8'h44);
    wait_req("fw", 4, w);
    check_val("fw_lat", w, 32'd1);
    expect_req("fw", 1'b1, 32'd4, 32'h4433_2211, 32'hFFFF_FFFF, 4'b1111);
    ack("fw", 32'h0);
    wait_req("fw_rd", 4, w);
    expect_req("fw_rd", 1'b0, 32'd5, 32'd0, 32'd0, 4'b0000);
    ack("fw_rd", 32'h8765_4321);
    check_val("fw_ptr_i2cdo", 32'(I2CDO), 32'h21);

    // Partial write flushed by timeout
    do_as(8'h21); do_wr(8'hAA); do_wr(8'hBB);
    early = 0;
    for (int i = 0; i < FLUSH_TMO; i++) begin
      step();
      if (BREQ) early++;
    end
    check_val("pw_no_early", early, 32'd0);
    wait_req("pw", 4, w);
    check_val("pw_lat", w, 32'd1);
    expect_req("pw", 1'b1, 32'd8, 32'h00BB_AA00, 32'h00FF_FF00, 4'b0110);
    ack("pw", 32'h0);
    wait_req("pw_rd", 4, w);
    expect_req("pw_rd", 1'b0, 32'd8, 32'd0, 32'd0, 4'b0000);
    ack("pw_rd", 32'h1122_3344);
    check_val("pw_i2cdo", 32'(I2CDO), 32'h11);

    // Read with prefetch
    do_as(8'h05);
    wait_req("rp", 4, w);
    expect_req("rp", 1'b0, 32'd1, 32'd0, 32'd0, 4'b0000);
    ack("rp", 32'hDDCC_BBAA);
    check_val("rp_b0", 32'(I2CDO), 32'hBB);
    do_rd();
    check_val("rp_b1", 32'(I2CDO), 32'hCC);
    do_rd();
    check_val("rp_b2", 32'(I2CDO), 32'hDD);
    do_rd();
    check_val("rp_cross_ff", 32'(I2CDO), 32'hFF);
    wait_req("rp2", 4, w);
    check_val("rp2_lat", w, 32'd1);
    check_val("rp2_ff_pending", 32'(I2CDO), 32'hFF);
    expect_req("rp2", 1'b0, 32'd2, 32'd0, 32'd0, 4'b0000);
    ack("rp2", 32'h1A2B_3C4D);
    check_val("rp2_i2cdo", 32'(I2CDO), 32'h4D);

    // Pointer wrap
    do_as(8'hFE);
    wait_req("wr0", 4, w);
    expect_req("wr0", 1'b0, 32'h3F, 32'd0, 32'd0, 4'b0000);
    ack("wr0", 32'hA1B2_C3D4);
    check_val("wrap_fe", 32'(I2CDO), 32'hB2);
    do_rd();
    check_val("wrap_ff", 32'(I2CDO), 32'hA1);
    do_rd();
    check_val("wrap_00_ff", 32'(I2CDO), 32'hFF);
    wait_req("wr1", 4, w);
    expect_req("wr1", 1'b0, 32'd0, 32'd0, 32'd0, 4'b0000);
    ack("wr1", 32'h5566_7788);
    check_val("wrap_p00", 32'(I2CDO), 32'h88);
    do_rd();
    check_val("wrap_p01", 32'(I2CDO), 32'h77);
    check_val("wrap_err", 32'(ERR), 32'd0);

    // AS during an outstanding read discards it
    do_as(8'h30);
    wait_req("sa", 4, w);
    expect_req("sa", 1'b0, 32'h0C, 32'd0, 32'd0, 4'b0000);
    do_as(8'h40);
    ack("sa", 32'h0BAD_0BAD);
    check_val("sa_discard", 32'(I2CDO), 32'hFF);
    wait_req("sa2", 4, w);
    expect_req("sa2", 1'b0, 32'h10, 32'd0, 32'd0, 4'b0000);
    ack("sa2", 32'hCAFE_F00D);
    check_val("sa2_i2cdo", 32'(I2CDO), 32'h0D);

    // WR during an outstanding read: write flushes first, then a fresh read
    do_as(8'h44);
    wait_req("sw", 4, w);
    expect_req("sw", 1'b0, 32'h11, 32'd0, 32'd0, 4'b0000);
    do_wr(8'h5A);
    ack("sw", 32'hFFFF_FFFF);
    check_val("sw_discard", 32'(I2CDO), 32'hFF);
    wait_req("sw_wr", FLUSH_TMO + 8, w);
    expect_req("sw_wr", 1'b1, 32'h11, 32'h0000_005A, 32'h0000_00FF, 4'b0001);
    ack("sw_wr", 32'h0);
    wait_req("sw_rd", 4, w);
    expect_req("sw_rd", 1'b0, 32'h11, 32'd0, 32'd0, 4'b0000);
    ack("sw_rd", 32'h4433_2211);
    check_val("sw_i2cdo", 32'(I2CDO), 32'h22);

    // RD overrun and ERRCLR
    do_as(8'h80);
    wait_req("ov", 4, w);
    do_rd();
    check_val("ov_err_set", 32'(ERR), 32'd1);
    ERRCLR = 1'b1; step(); ERRCLR = 1'b0;
    check_val("ov_err_clr", 32'(ERR), 32'd0);
    ERRCLR = 1'b1; do_rd(); ERRCLR = 1'b0;
    check_val("ov_err_wins", 32'(ERR), 32'd1);
    ERRCLR = 1'b1; step(); ERRCLR = 1'b0;
    check_val("ov_err_clr2", 32'(ERR), 32'd0);
    ack("ov", 32'h1122_3344);
    check_val("ov_i2cdo", 32'(I2CDO), 32'h22);

    // WR while a flush is pending is dropped
    do_as(8'h90); do_wr(8'h01); do_wr(8'h02); do_wr(8'h03); do_wr(8'h04);
    do_wr(8'h99);
    check_val("wo_err", 32'(ERR), 32'd1);
    wait_req("wo", 4, w);
    expect_req("wo", 1'b1, 32'h24, 32'h0403_0201, 32'hFFFF_FFFF, 4'b1111);
    ack("wo", 32'h0);
    wait_req("wo_rd", 4, w);
    expect_req("wo_rd", 1'b0, 32'h25, 32'd0, 32'd0, 4'b0000);
    ack("wo_rd", 32'hD4C3_B2A1);
    check_val("wo_ptr_held", 32'(I2CDO), 32'hA1);

    // Reset in the middle of a write cycle, with BACK arriving in the same cycle
    do_as(8'hA0); do_wr(8'h10); do_wr(8'h20); do_wr(8'h30); do_wr(8'h40);
    wait_req("rw", 4, w);
    expect_req("rw", 1'b1, 32'h28, 32'h4030_2010, 32'hFFFF_FFFF, 4'b1111);
    RST = 1'b1; BACK = 1'b1; step(); BACK = 1'b0;
    check_val("rw_breq", 32'(BREQ), 32'd0);
    check_val("rw_bwe", 32'(BWE), 32'd0);
    check_val("rw_baddr", 32'(BADDR), 32'd0);
    check_val("rw_bdato", BDATO, 32'd0);
    check_val("rw_bbe", 32'(BBE), 32'd0);
    check_val("rw_err", 32'(ERR), 32'd0);
    check_val("rw_i2cdo", 32'(I2CDO), 32'h0000_00FF);
    RST = 1'b0; step();
    check_val("rw_ff_breq", 32'(BREQ), 32'd1);
    expect_req("rw_ff", 1'b0, 32'd0, 32'd0, 32'd0, 4'b0000);
    ack("rw_ff", 32'h0000_00E7);
    check_val("rw_ff_i2cdo", 32'(I2CDO), 32'hE7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_bridge.md
# i2c_bus_bridge

Downstream companion of the I2C slave front-end. Converts the slave's byte strobes (AS = register pointer byte, WR = data byte, RD = byte consumed) into 32-bit word cycles on the internal register bus, and keeps the slave's read-data input permanently loaded with the byte at the current pointer. Partial writes are write-combined into one byte-enabled bus write. Read data is prefetched so it is valid before the slave samples it.

## Interface
- ADDR_W, 8: byte pointer width; bus word address is ADDR_W-2 bits.
- FLUSH_TMO, 1024: idle CLK cycles after the last WR before a partial write buffer is flushed.

- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- AS  in  1  one-cycle strobe from the slave; I2CDI holds the new pointer.
- WR  in  1  one-cycle strobe from the slave; I2CDI holds a data byte.
- RD  in  1  one-cycle strobe from the slave; the current I2CDO byte was consumed.
- I2CDI  in  8  byte from the slave.
- I2CDO  out  8  byte to the slave's read-data input.
- BREQ  out  1  bus request.
- BWE  out  1  1 = write, 0 = read.
- BADDR  out  ADDR_W-2  word address.
- BDATO  out  32  write data.
- BBE  out  4  write byte enables.
- BDATI  in  32  read data, valid in the BACK cycle.
- BACK  in  1  one-cycle bus acknowledge.
- ERR  out  1  sticky overrun flag.
- ERRCLR  in  1  clears ERR.

## Operation
- **Byte order:** little-endian. Byte at pointer p maps to word p[ADDR_W-1:2], lane p[1:0]. Lane 0 is bits [7:0].
- **Internal state:**
  - PTR: byte pointer.
  - Read buffer: RBUF (32-bit word), RVALID flag.
  - Write buffer: WBUF, WBE[3:0], WADDR, WPEND (flush pending).
  - TMO counter.
- **I2CDO:** RBUF lane PTR[1:0] when RVALID = 1; otherwise 8'hFF. Driven from registers only.
- **AS:**
  - PTR ← I2CDI; RVALID ← 0.
  - If WBE ≠ 0, WPEND ← 1.
- **WR:**
  - If WPEND = 1: the byte is dropped, PTR is unchanged, and ERR ← 1.
  - Otherwise: write the byte into WBUF lane PTR[1:0], set the matching WBE bit, WADDR ← PTR word, PTR ← PTR+1, RVALID ← 0, TMO ← 0.
  - If the written lane is 3, WPEND ← 1.
- **RD:**
  - If RVALID = 0, ERR ← 1.
  - PTR ← PTR+1.
  - If the new PTR[1:0] = 0, RVALID ← 0.
- **PTR wrap:** PTR wraps modulo 2^ADDR_W (8'hFF+1 → 8'h00).
- **Timeout flush:** when WBE ≠ 0, WPEND = 0 and TMO = FLUSH_TMO-1, set WPEND ← 1. TMO counts only while WBE ≠ 0 and is held at 0 otherwise.
- **State machine:** IDLE, WCYC, RCYC.
  - IDLE → WCYC when WPEND = 1. This has priority over a read.
    - Load BADDR ← WADDR, BDATO ← WBUF, BBE ← WBE, BWE ← 1, BREQ ← 1.
    - Clear WBE and WPEND in the same cycle, so the buffer can accept new bytes immediately.
  - IDLE → RCYC when RVALID = 0, WBE = 0, WPEND = 0 and no strobe is present this cycle.
    - BADDR ← PTR word, BWE ← 0, BBE ← 0, BREQ ← 1.
    - Clear the internal STALE flag.
  - WCYC/RCYC → IDLE on BACK, with BREQ ← 0.
    - RCYC: RBUF ← BDATI and RVALID ← 1, unless STALE = 1, in which case RVALID stays 0.
- **Discarding stale reads:** AS, WR, or an RD that crosses a word boundary during RCYC sets STALE. The fetch result is discarded, and a new fetch is issued from IDLE afterwards.
- **Speculative reads:** bus targets in this window must have no read side effects.
- **ERRCLR:** clears ERR. A simultaneous error event wins, leaving ERR = 1.

## Timing
- **RST:** every register returns to its reset value; this holds even in the middle of a bus cycle. BREQ drops the next cycle, and a pending BACK is ignored.
- **Reset values:**
  - Outputs: BREQ=0, BWE=0, BADDR=0, BDATO=0, BBE=0, ERR=0, I2CDO=8'hFF.
  - Internal: PTR=0, RVALID=0, WBE=0, WPEND=0, TMO=0, STALE=0.
- **First fetch after reset:** BREQ asserts 1 cycle after RST is deasserted, for word 0.
- **Strobe latency:** strobe in cycle n → internal state updated at the edge ending n. WPEND set by a lane-3 WR → BREQ high at n+2 if the FSM is IDLE.
- **Bus handshake:** BREQ, BWE, BADDR, BDATO and BBE are held stable from assertion through the BACK cycle. BREQ is low the cycle after BACK. BACK in the same cycle BREQ rises is legal.
- **Fetch latency:** a word-crossing RD at cycle n → BREQ at n+2 (IDLE, no write pending). The data is valid in the cycle after BACK.
- **Timeout flush:** the last WR at cycle n → WPEND set FLUSH_TMO cycles later.
- **Read-after-write:** a read fetch never starts while write data is buffered or pending.

## Test plan
- **Full-word write:** AS 0x10, then WR 0x11, 0x22, 0x33, 0x44 → one write with BADDR=4, BDATO=0x44332211, BBE=4'b1111. PTR ends at 0x14.
- **Partial write with timeout:** AS 0x21, then WR 0xAA, 0xBB → after FLUSH_TMO idle cycles, one write with BADDR=8, BBE=4'b0110, BDATO[15:8]=0xAA, BDATO[23:16]=0xBB. No write occurs earlier.
- **Read with prefetch:** AS 0x05; bus returns 0xDDCCBBAA for word 1 → I2CDO reads 0xBB, 0xCC, 0xDD across successive RDs. The third RD triggers a read of word 2. I2CDO=8'hFF until that BACK arrives.
- **Pointer wrap:** AS 0xFE, then 3 RDs → fetch of word 0 after wrap; PTR=0x01.
- **AS during read:** AS 0x40 while RCYC is outstanding → the old data is discarded, then a new read with BADDR=0x10 is issued. A WR in the same situation leads to a write, then a read.
- **Overrun and reset:**
  - BACK withheld, RD issued while RVALID=0 → ERR=1; ERRCLR clears it.
  - WR while WPEND=1 → ERR=1, byte dropped.
  - RST during WCYC → all outputs return to reset values the next cycle.
